pe_operand_stage: RTL and testbench
===================================

PE_OPERAND_STAGE -- requirements
Module: pe_operand_stage

Interface
REQ-001 Parameter DW, default `DATA_SIZE*2 (32): width of every data token (high half tag, low half value).
REQ-002 Parameter DEPTH, default 2: entries per operand FIFO; legal values 2 and 4 only.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 cfgValid  in  1  load-configuration strobe.
REQ-006 cfgFunc  in  4  ALU function code to load.
REQ-007 cfgUse  in  2  operand-use mask: bit0 = operand 0 required, bit1 = operand 1 required.
REQ-008 in0Valid / in0Ready / in0Data  in / out / in  1 / 1 / DW  operand-0 token channel.
REQ-009 in1Valid / in1Ready / in1Data  in / out / in  1 / 1 / DW  operand-1 token channel.
REQ-010 aluData0 / aluData1 / aluFunc  out / out / out  DW / DW / 4  drive the downstream ALU inData0 / inData1 / funcSel.
REQ-011 aluResult  in  DW  combinational ALU outData.
REQ-012 outValid / outReady / outData  out / in / out  1 / 1 / DW  result token channel.
REQ-013 busy  out  1  high when any FIFO is non-empty or outValid is high.

Function
REQ-014 The block SHALL accept a token on channel X at a rising edge iff inXValid and inXReady are both high at that edge.
REQ-015 inXReady SHALL equal (FIFO X count < DEPTH), registered-state only, with no combinational path from outReady or inXValid.
REQ-016 Each FIFO SHALL be first-in first-out, with wrap-around read/write pointers; push and pop in the same cycle at count 1 leaves count 1 and the head advances.
REQ-017 fire SHALL be high iff, for every operand b with cfgUse[b]=1, FIFO b is non-empty; cfgUse is non-zero; and (outValid=0 or outReady=1).
REQ-018 aluData0/aluData1 SHALL present FIFO heads combinationally when the operand is used, else all-zero; aluFunc SHALL present the func register.
REQ-019 On a firing edge, the block SHALL pop every used FIFO, load outData with aluResult and set outValid=1.
REQ-020 outValid SHALL clear on an edge with outValid=1, outReady=1 and fire=0; outData SHALL hold its value until the next fire.
REQ-021 Latency: a token accepted at edge k that completes an operand set SHALL yield outValid=1 after edge k+1 (one cycle); throughput one result per cycle with outReady held high.
REQ-022 Unused-operand FIFOs SHALL still accept tokens while not full and SHALL never be popped.
REQ-023 cfgValid SHALL load cfgFunc/cfgUse only when busy=0 and no token is accepted in that cycle; otherwise it SHALL be ignored without side effects.
REQ-024 cfgUse=2'b00 SHALL never fire; tokens accumulate until FIFOs are full.
REQ-025 Simultaneous fire and push into the same FIFO at count DEPTH is impossible because inXReady=0; no overflow or underflow SHALL occur under any input sequence.

Reset
REQ-026 On rst_n low, asynchronously: FIFO counts and pointers 0, inXReady=1 after release, outValid=0, outData=0, func register 4'd0, cfgUse register 2'b11, busy=0.
REQ-027 Reset asserted mid-operation SHALL discard all buffered and output tokens; the first accepted token after release is treated as the first ever.

Verification
REQ-028 ADD cfg (use=11); in0=0x0001_0005 at edge 1, in1=0x0000_0003 at edge 2, with real alu attached -> outValid after edge 3, outData=0x0001_0008.
REQ-029 use=10 with IN1 cfg; in1=0x0000_0042 only -> outData=0x0000_0042, aluData0=0, FIFO0 untouched.
REQ-030 outReady=0, three operand pairs streamed -> one result held stable, both FIFOs fill to DEPTH, inXReady=0; outReady=1 -> results drain in order, one per cycle.
REQ-031 cfgValid pulsed while busy=1 -> func unchanged; pulsed when idle -> new func seen on aluFunc next cycle.
REQ-032 rst_n dropped with FIFOs full and outValid=1 -> outValid=0, busy=0 immediately; post-reset pair produces exactly one result.
REQ-033 Random valid/ready stall stress, 10k tokens -> scoreboard ordering match, no drop or duplicate.

Source files
------------

// File: rtl/pe_operand_stage_if.sv
// Operand and result token channels of the PE operand stage.
// The master modport is the producer/consumer side; the slave modport is the stage itself.
interface pe_operand_stage_if #(
  parameter int DW = 32
);
  logic          in0Valid;
  logic          in0Ready;
  logic [DW-1:0] in0Data;
  logic          in1Valid;
  logic          in1Ready;
  logic [DW-1:0] in1Data;
  logic          outValid;
  logic          outReady;
  logic [DW-1:0] outData;

  modport master (
    output in0Valid, in0Data, input in0Ready,
    output in1Valid, in1Data, input in1Ready,
    input  outValid, outData, output outReady
  );

  modport slave (
    input  in0Valid, in0Data, output in0Ready,
    input  in1Valid, in1Data, output in1Ready,
    output outValid, outData, input outReady
  );
endinterface

// File: rtl/pe_operand_stage.sv
// Operand-matching stage: buffers two token streams and issues one ALU op per complete operand set.
// Result is valid one cycle after the completing token; inXReady depends only on FIFO fill, never on outReady.
module pe_operand_stage #(
  parameter int DW    = 32,
  parameter int DEPTH = 2   // 2 or 4 only; pointers rely on power-of-two wrap
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfgValid,
  input  logic [3:0]        cfgFunc,
  input  logic [1:0]        cfgUse,
  pe_operand_stage_if.slave bus,
  output logic [DW-1:0]     aluData0,
  output logic [DW-1:0]     aluData1,
  output logic [3:0]        aluFunc,
  input  logic [DW-1:0]     aluResult,
  output logic              busy
);
  localparam int            PW       = $clog2(DEPTH);
  localparam logic [PW:0]   FULL_CNT = (PW+1)'(DEPTH);
  localparam logic [PW:0]   CNT_ONE  = (PW+1)'(1);
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);

  logic [1:0]    inValid;
  logic [1:0]    inReady;
  logic [1:0]    push;
  logic [1:0]    pop;
  logic [1:0]    nonEmpty;
  logic [DW-1:0] inData [2];
  logic [DW-1:0] mem [2][DEPTH];
  logic [PW-1:0] wrPtr [2];
  logic [PW-1:0] rdPtr [2];
  logic [PW:0]   count [2];
  logic [3:0]    funcReg;
  logic [1:0]    useReg;
  logic          outValidReg;
  logic [DW-1:0] outDataReg;
  logic          fire;
  logic          cfgLoad;

  assign inValid      = {bus.in1Valid, bus.in0Valid};
  assign inData[0]    = bus.in0Data;
  assign inData[1]    = bus.in1Data;
  assign bus.in0Ready = inReady[0];
  assign bus.in1Ready = inReady[1];
  assign bus.outValid = outValidReg;
  assign bus.outData  = outDataReg;

  always_comb begin
    inReady  = '0;
    nonEmpty = '0;
    push     = '0;
    for (int b = 0; b < 2; b++) begin
      inReady[b]  = (count[b] < FULL_CNT);
      nonEmpty[b] = (count[b] != '0);
      push[b]     = inValid[b] & inReady[b];
    end
  end

  // An operand that is not in the use mask never gates issue and is never popped.
  assign fire = (useReg != 2'b00)
              && (nonEmpty[0] || !useReg[0])
              && (nonEmpty[1] || !useReg[1])
              && (!outValidReg || bus.outReady);
  assign pop     = fire ? useReg : 2'b00;
  assign busy    = (nonEmpty != 2'b00) || outValidReg;
  assign cfgLoad = cfgValid && !busy && (push == 2'b00);

  assign aluData0 = useReg[0] ? mem[0][rdPtr[0]] : '0;
  assign aluData1 = useReg[1] ? mem[1][rdPtr[1]] : '0;
  assign aluFunc  = funcReg;

  always_ff @(posedge clk) begin
    for (int b = 0; b < 2; b++) begin
      if (push[b]) mem[b][wrPtr[b]] <= inData[b];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int b = 0; b < 2; b++) begin
        wrPtr[b] <= '0;
        rdPtr[b] <= '0;
        count[b] <= '0;
      end
    end else begin
      for (int b = 0; b < 2; b++) begin
        if (push[b]) wrPtr[b] <= wrPtr[b] + PTR_ONE;
        if (pop[b])  rdPtr[b] <= rdPtr[b] + PTR_ONE;
        if (push[b] && !pop[b])      count[b] <= count[b] + CNT_ONE;
        else if (pop[b] && !push[b]) count[b] <= count[b] - CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outValidReg <= 1'b0;
      outDataReg  <= '0;
    end else if (fire) begin
      outValidReg <= 1'b1;
      outDataReg  <= aluResult;
    end else if (bus.outReady) begin
      outValidReg <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      funcReg <= 4'd0;
      useReg  <= 2'b11;
    end else if (cfgLoad) begin
      funcReg <= cfgFunc;
      useReg  <= cfgUse;
    end
  end
endmodule

// File: tb/tb_pe_operand_stage.sv
// Directed and random bench for pe_operand_stage with an attached reference ALU and a result scoreboard.
module tb_pe_operand_stage;
  localparam int N = 5000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cfgValid = 1'b0;
  logic [3:0]  cfgFunc = 4'd0;
  logic [1:0]  cfgUse = 2'b11;
  logic [31:0] aluData0, aluData1, aluResult;
  logic [3:0]  aluFunc;
  logic        busy;

  int tests = 0;
  int fails = 0;
  int nResults = 0;

  // Scoreboard: operand queues per channel, expected results in issue order
  logic [31:0] m0[$];
  logic [31:0] m1[$];
  logic [31:0] expQ[$];
  logic [3:0]  mFunc = 4'd0;
  logic [1:0]  mUse = 2'b11;

  pe_operand_stage_if #(.DW(32)) bus ();

  pe_operand_stage #(.DW(32), .DEPTH(2)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cfgValid (cfgValid),
    .cfgFunc  (cfgFunc),
    .cfgUse   (cfgUse),
    .bus      (bus),
    .aluData0 (aluData0),
    .aluData1 (aluData1),
    .aluFunc  (aluFunc),
    .aluResult(aluResult),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  // Function codes: 0 ADD, 1 pass operand 1, 2 XOR, 3 pass operand 0
  function automatic logic [31:0] aluRef(input logic [3:0] f, input logic [31:0] a, input logic [31:0] b);
    case (f)
      4'd0:    return a + b;
      4'd1:    return b;
      4'd2:    return a ^ b;
      4'd3:    return a;
      default: return 32'd0;
    endcase
  endfunction

  always_comb aluResult = aluRef(aluFunc, aluData0, aluData1);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Observe handshakes away from the edge; inputs only change at posedge+1
  always @(negedge clk) begin
    bit a0, a1;
    logic [31:0] x, y;
    if (rst_n) begin
      a0 = bus.in0Valid && bus.in0Ready;
      a1 = bus.in1Valid && bus.in1Ready;
      if (cfgValid && m0.size() == 0 && m1.size() == 0 && expQ.size() == 0 && !a0 && !a1) begin
        mFunc = cfgFunc;
        mUse  = cfgUse;
      end
      if (bus.outValid && bus.outReady) begin
        nResults++;
        if (expQ.size() == 0) chk("sb_extra_result", 32'(expQ.size()), 32'd1);
        else chk("sb_data", bus.outData, expQ.pop_front());
      end
      if (a0) m0.push_back(bus.in0Data);
      if (a1) m1.push_back(bus.in1Data);
      while (mUse != 2'b00 && (!mUse[0] || m0.size() > 0) && (!mUse[1] || m1.size() > 0)) begin
        x = mUse[0] ? m0.pop_front() : 32'd0;
        y = mUse[1] ? m1.pop_front() : 32'd0;
        expQ.push_back(aluRef(mFunc, x, y));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg(input logic [3:0] f, input logic [1:0] u);
    cfgFunc  = f;
    cfgUse   = u;
    cfgValid = 1'b1;
    tick();
    cfgValid = 1'b0;
  endtask

  task automatic send0(input logic [31:0] d);
    bus.in0Valid = 1'b1;
    bus.in0Data  = d;
    @(negedge clk);
    chk("in0Ready_on_send", 32'(bus.in0Ready), 32'd1);
    tick();
    bus.in0Valid = 1'b0;
  endtask

  task automatic send1(input logic [31:0] d);
    bus.in1Valid = 1'b1;
    bus.in1Data  = d;
    @(negedge clk);
    chk("in1Ready_on_send", 32'(bus.in1Ready), 32'd1);
    tick();
    bus.in1Valid = 1'b0;
  endtask

  task automatic sendPair(input logic [31:0] a, input logic [31:0] b);
    bus.in0Valid = 1'b1;
    bus.in0Data  = a;
    bus.in1Valid = 1'b1;
    bus.in1Data  = b;
    @(negedge clk);
    chk("pairReady_on_send", {30'd0, bus.in1Ready, bus.in0Ready}, 32'd3);
    tick();
    bus.in0Valid = 1'b0;
    bus.in1Valid = 1'b0;
  endtask

  initial begin
    int base, s0, s1;
    bit acc0, acc1;
    bus.in0Valid = 1'b0;
    bus.in0Data  = '0;
    bus.in1Valid = 1'b0;
    bus.in1Data  = '0;
    bus.outReady = 1'b1;

    // Reset state
    repeat (2) tick();
    chk("rst_in0Ready", 32'(bus.in0Ready), 32'd1);
    chk("rst_in1Ready", 32'(bus.in1Ready), 32'd1);
    chk("rst_outValid", 32'(bus.outValid), 32'd0);
    chk("rst_outData", bus.outData, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_aluFunc", 32'(aluFunc), 32'd0);
    rst_n = 1'b1;
    tick();

    // ADD with staggered operands: result one cycle after the completing token
    cfg(4'd0, 2'b11);
    send0(32'h0001_0005);
    send1(32'h0000_0003);
    chk("lat_not_yet", 32'(bus.outValid), 32'd0);
    tick();
    chk("lat_outValid", 32'(bus.outValid), 32'd1);
    chk("add_outData", bus.outData, 32'h0001_0008);
    tick();
    chk("add_cleared", 32'(bus.outValid), 32'd0);
    chk("add_idle", 32'(busy), 32'd0);

    // Single-operand use mask: operand 0 masked to zero, FIFO0 left alone
    cfg(4'd1, 2'b10);
    chk("cfg_in1_func", 32'(aluFunc), 32'd1);
    send1(32'h0000_0042);
    chk("use10_aluData0", aluData0, 32'd0);
    chk("use10_aluData1", aluData1, 32'h0000_0042);
    tick();
    chk("use10_outValid", 32'(bus.outValid), 32'd1);
    chk("use10_outData", bus.outData, 32'h0000_0042);
    chk("use10_in0Ready", 32'(bus.in0Ready), 32'd1);
    tick();
    chk("use10_idle", 32'(busy), 32'd0);
    cfg(4'd0, 2'b11);

    // Configuration is ignored while busy and taken when idle
    send0(32'h0000_0010);
    chk("busy_half_set", 32'(busy), 32'd1);
    cfg(4'd2, 2'b11);
    chk("cfg_ignored_busy", 32'(aluFunc), 32'd0);
    send1(32'h0000_0020);
    tick();
    chk("busy_add_data", bus.outData, 32'h0000_0030);
    tick();
    chk("busy_drained", 32'(busy), 32'd0);
    cfg(4'd2, 2'b11);
    chk("cfg_taken_idle", 32'(aluFunc), 32'd2);
    sendPair(32'hF0F0_0000, 32'h0FF0_00FF);
    tick();
    chk("xor_outData", bus.outData, 32'hFF00_00FF);
    tick();
    cfg(4'd0, 2'b11);

    // Output stall: one result held, both FIFOs fill, then drain in order
    bus.outReady = 1'b0;
    sendPair(32'h0000_0001, 32'h0000_0010);
    sendPair(32'h0000_0002, 32'h0000_0020);
    sendPair(32'h0000_0003, 32'h0000_0030);
    chk("full_in0Ready", 32'(bus.in0Ready), 32'd0);
    chk("full_in1Ready", 32'(bus.in1Ready), 32'd0);
    chk("stall_outValid", 32'(bus.outValid), 32'd1);
    chk("stall_outData", bus.outData, 32'h0000_0011);
    tick();
    chk("stall_hold", bus.outData, 32'h0000_0011);
    bus.outReady = 1'b1;
    tick();
    chk("drain_r1_valid", 32'(bus.outValid), 32'd1);
    chk("drain_r1", bus.outData, 32'h0000_0022);
    tick();
    chk("drain_r2", bus.outData, 32'h0000_0033);
    tick();
    chk("drain_done", 32'(bus.outValid), 32'd0);

    // Reset with full FIFOs and a pending result
    bus.outReady = 1'b0;
    sendPair(32'h0000_0100, 32'h0000_0001);
    sendPair(32'h0000_0200, 32'h0000_0002);
    sendPair(32'h0000_0300, 32'h0000_0003);
    #2;
    rst_n = 1'b0;
    m0.delete();
    m1.delete();
    expQ.delete();
    mFunc = 4'd0;
    mUse  = 2'b11;
    #1;
    chk("arst_outValid", 32'(bus.outValid), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_in0Ready", 32'(bus.in0Ready), 32'd1);
    tick();
    rst_n = 1'b1;
    bus.outReady = 1'b1;
    base = nResults;
    tick();
    sendPair(32'h0000_0005, 32'h0000_0006);
    repeat (3) tick();
    chk("post_rst_one_result", 32'(nResults - base), 32'd1);
    chk("post_rst_idle", 32'(busy), 32'd0);

    // Random valid/ready stress
    base = nResults;
    s0 = 0;
    s1 = 0;
    for (int cyc = 0; cyc < 40000; cyc++) begin
      if (s0 == N && s1 == N && !bus.in0Valid && !bus.in1Valid) break;
      @(negedge clk);
      acc0 = bus.in0Valid && bus.in0Ready;
      acc1 = bus.in1Valid && bus.in1Ready;
      tick();
      if (acc0) bus.in0Valid = 1'b0;
      if (acc1) bus.in1Valid = 1'b0;
      if (!bus.in0Valid && s0 < N && $urandom_range(0, 99) < 60) begin
        bus.in0Valid = 1'b1;
        bus.in0Data  = $urandom;
        s0++;
      end
      if (!bus.in1Valid && s1 < N && $urandom_range(0, 99) < 60) begin
        bus.in1Valid = 1'b1;
        bus.in1Data  = $urandom;
        s1++;
      end
      bus.outReady = ($urandom_range(0, 99) < 70);
    end
    chk("stress_all_sent", {30'd0, bus.in1Valid, bus.in0Valid}, 32'd0);
    bus.outReady = 1'b1;
    for (int i = 0; i < 100; i++) begin
      if (expQ.size() == 0 && !busy) break;
      tick();
    end
    chk("stress_sb_empty", 32'(expQ.size()), 32'd0);
    chk("stress_idle", 32'(busy), 32'd0);
    chk("stress_count", 32'(nResults - base), 32'(N));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
